// File: rtl/pep_batch_definition_pkg.sv
// Batch geometry shared by the pe_pbs pipeline blocks.
//   BATCH_PBS_NB : maximum PBS requests grouped into one batch
//   TOTAL_PBS_NB : size of the PBS slot pool (multiple of GRAM_NB)
//   BATCH_NB     : maximum number of batches in flight downstream
//   GRAM_NB      : number of GRAM banks the slot pool is spread over
package pep_batch_definition_pkg;
    localparam int BATCH_PBS_NB = 9;
    localparam int TOTAL_PBS_NB = 18;
    localparam int BATCH_NB     = 1;
    localparam int GRAM_NB      = 3;
endpackage

// File: rtl/pep_common_param_pkg.sv
// Derived widths and the batch former state type.
//   PID_W : width of a PBS slot id
//   NB_W  : width of a PBS count in the range 0..BATCH_PBS_NB
package pep_common_param_pkg;
    import pep_batch_definition_pkg::*;

    localparam int PID_W = $clog2(TOTAL_PBS_NB);
    localparam int NB_W  = $clog2(BATCH_PBS_NB + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // no open batch
        ST_FILL  = 2'd1,  // partial batch open, accepting requests
        ST_ISSUE = 2'd2   // batch closed, command held until handshake
    } batch_state_e;
endpackage

// File: rtl/pep_batch_credit.sv
// Credit counters of the batch former: free PBS slots and batches in flight.
// Ports:
//   clk, s_rst      : clock, synchronous active-high reset
//   alloc_i         : one slot allocated this cycle
//   rel_vld_i/nb_i  : slots released this cycle
//   issue_i         : batch command handshake this cycle
//   done_i          : one in-flight batch finished this cycle
//   free_cnt_o      : registered free slot count
//   free_nxt_o      : free slot count after this cycle's updates
//   inflight_cnt_o  : registered in-flight batch count
module pep_batch_credit
    import pep_common_param_pkg::*;
#(
    parameter int  TOTAL_PBS_NB = pep_batch_definition_pkg::TOTAL_PBS_NB,
    parameter int  BATCH_NB     = pep_batch_definition_pkg::BATCH_NB,
    localparam int FREE_W       = $clog2(TOTAL_PBS_NB + 1),
    localparam int INFL_W       = $clog2(BATCH_NB + 1)
) (
    input  logic              clk,
    input  logic              s_rst,
    input  logic              alloc_i,
    input  logic              rel_vld_i,
    input  logic [NB_W-1:0]   rel_nb_i,
    input  logic              issue_i,
    input  logic              done_i,
    output logic [FREE_W-1:0] free_cnt_o,
    output logic [FREE_W-1:0] free_nxt_o,
    output logic [INFL_W-1:0] inflight_cnt_o
);
    localparam int SUM_W = FREE_W + 1;

    logic [FREE_W-1:0] free_cnt_q;
    logic [INFL_W-1:0] inflight_q, inflight_d;
    logic [SUM_W-1:0]  free_sum;
    logic              free_over;

    always_comb begin
        // One spare bit so an over-release is visible before clamping.
        free_sum = {1'b0, free_cnt_q};
        if (rel_vld_i) begin
            free_sum = free_sum + SUM_W'(rel_nb_i);
        end
        free_sum   = free_sum - SUM_W'(alloc_i);
        free_over  = free_sum > SUM_W'(TOTAL_PBS_NB);
        free_nxt_o = free_over ? FREE_W'(TOTAL_PBS_NB) : free_sum[FREE_W-1:0];
    end

    always_comb begin
        inflight_d = inflight_q;
        if (issue_i && !done_i) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue_i && done_i && (inflight_q != '0)) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            free_cnt_q <= FREE_W'(TOTAL_PBS_NB);
            inflight_q <= '0;
        end else begin
            free_cnt_q <= free_nxt_o;
            inflight_q <= inflight_d;
        end
    end

    assign free_cnt_o     = free_cnt_q;
    assign inflight_cnt_o = inflight_q;

    a_done_underflow: assert property (@(posedge clk) disable iff (s_rst)
        !(done_i && !issue_i && (inflight_q == '0)));
    a_free_overflow: assert property (@(posedge clk) disable iff (s_rst)
        !free_over);
endmodule

// File: rtl/pep_batch_former.sv
// Groups PBS requests into batches for the pe_pbs batch-processing stage.
// Each accepted request is given the next slot id of a circular pool; a
// batch closes when full, on flush, on timeout or when the pool runs dry,
// and is then offered as a single command while downstream has room.
// Ports:
//   clk, s_rst                     : clock, synchronous active-high reset
//   req_vld/req_rdy/req_pid        : request handshake, allocated slot id
//   flush                          : close the open partial batch
//   bcmd_vld/rdy/pid_first/pbs_nb  : batch command handshake and payload
//   batch_done                     : one in-flight batch finished
//   pbs_free_vld/pbs_free_nb       : slots returned to the pool
//   free_cnt/inflight_cnt          : credit status
module pep_batch_former
    import pep_common_param_pkg::*;
#(
    parameter int  BATCH_PBS_NB   = pep_batch_definition_pkg::BATCH_PBS_NB,
    parameter int  TOTAL_PBS_NB   = pep_batch_definition_pkg::TOTAL_PBS_NB,
    parameter int  BATCH_NB       = pep_batch_definition_pkg::BATCH_NB,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int FREE_W         = $clog2(TOTAL_PBS_NB + 1),
    localparam int INFL_W         = $clog2(BATCH_NB + 1)
) (
    input  logic              clk,
    input  logic              s_rst,
    input  logic              req_vld,
    output logic              req_rdy,
    output logic [PID_W-1:0]  req_pid,
    input  logic              flush,
    output logic              bcmd_vld,
    input  logic              bcmd_rdy,
    output logic [PID_W-1:0]  bcmd_pid_first,
    output logic [NB_W-1:0]   bcmd_pbs_nb,
    input  logic              batch_done,
    input  logic              pbs_free_vld,
    input  logic [NB_W-1:0]   pbs_free_nb,
    output logic [FREE_W-1:0] free_cnt,
    output logic [INFL_W-1:0] inflight_cnt
);
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PID_W-1:0] PID_LAST = PID_W'(TOTAL_PBS_NB - 1);
    localparam logic [NB_W-1:0]  NB_FULL  = NB_W'(BATCH_PBS_NB);

    if ((TOTAL_PBS_NB % pep_batch_definition_pkg::GRAM_NB) != 0) begin : g_bad_total
        $error("TOTAL_PBS_NB must be a multiple of GRAM_NB");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    batch_state_e      state_q, state_d;
    logic [PID_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PID_W-1:0]  pid_first_q, pid_first_d;
    logic [NB_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              accept;
    logic              bcmd_hs;
    logic              close;
    logic [FREE_W-1:0] free_nxt;

    // Gating with s_rst keeps a reset cycle from accepting or issuing.
    assign req_rdy  = (state_q != ST_ISSUE) && (free_cnt != '0) && !s_rst;
    assign accept   = req_vld && req_rdy;
    assign bcmd_vld = (state_q == ST_ISSUE) && (inflight_cnt < INFL_W'(BATCH_NB)) && !s_rst;
    assign bcmd_hs  = bcmd_vld && bcmd_rdy;

    assign req_pid        = wr_ptr_q;
    assign bcmd_pid_first = pid_first_q;
    assign bcmd_pbs_nb    = fill_cnt_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        pid_first_d = pid_first_q;
        fill_cnt_d  = fill_cnt_q;
        timer_d     = timer_q;
        close       = 1'b0;

        if (accept) begin
            wr_ptr_d = (wr_ptr_q == PID_LAST) ? '0 : wr_ptr_q + 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_FILL: begin
                if ((state_q == ST_FILL) && (timer_q != TMR_LAST)) begin
                    timer_d = timer_q + 1'b1;
                end
                if (accept) begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (state_q == ST_IDLE) begin
                        pid_first_d = wr_ptr_q;
                        timer_d     = '0;
                    end
                end
                // Close on the values this cycle produces, so the accept
                // that fills the batch or drains the pool closes it at once.
                close = (fill_cnt_d == NB_FULL) ||
                        ((fill_cnt_d != '0) &&
                         (flush || (timer_d == TMR_LAST) || (free_nxt == '0)));
                if (close) begin
                    state_d = ST_ISSUE;
                end else if (fill_cnt_d != '0) begin
                    state_d = ST_FILL;
                end
            end
            ST_ISSUE: begin
                if (bcmd_hs) begin
                    fill_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            pid_first_q <= '0;
            fill_cnt_q  <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            pid_first_q <= pid_first_d;
            fill_cnt_q  <= fill_cnt_d;
            timer_q     <= timer_d;
        end
    end

    pep_batch_credit #(
        .TOTAL_PBS_NB (TOTAL_PBS_NB),
        .BATCH_NB     (BATCH_NB)
    ) u_credit (
        .clk            (clk),
        .s_rst          (s_rst),
        .alloc_i        (accept),
        .rel_vld_i      (pbs_free_vld),
        .rel_nb_i       (pbs_free_nb),
        .issue_i        (bcmd_hs),
        .done_i         (batch_done),
        .free_cnt_o     (free_cnt),
        .free_nxt_o     (free_nxt),
        .inflight_cnt_o (inflight_cnt)
    );
endmodule

// File: tb/tb_pep_batch_former.sv
// Self-checking bench for pep_batch_former: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model that
// tracks the open batch as a queue of slot ids.
module tb_pep_batch_former;
    import pep_common_param_pkg::*;

    localparam int BATCH  = 9;
    localparam int TOTAL  = 18;
    localparam int BNB    = 1;
    localparam int TO     = 64;
    localparam int FREE_W = $clog2(TOTAL + 1);
    localparam int INFL_W = $clog2(BNB + 1);

    logic              clk = 1'b0;
    logic              s_rst = 1'b1;
    logic              req_vld = 1'b0;
    logic              req_rdy;
    logic [PID_W-1:0]  req_pid;
    logic              flush = 1'b0;
    logic              bcmd_vld;
    logic              bcmd_rdy = 1'b0;
    logic [PID_W-1:0]  bcmd_pid_first;
    logic [NB_W-1:0]   bcmd_pbs_nb;
    logic              batch_done = 1'b0;
    logic              pbs_free_vld = 1'b0;
    logic [NB_W-1:0]   pbs_free_nb = '0;
    logic [FREE_W-1:0] free_cnt;
    logic [INFL_W-1:0] inflight_cnt;

    always #5 clk = ~clk;

    pep_batch_former #(
        .BATCH_PBS_NB   (BATCH),
        .TOTAL_PBS_NB   (TOTAL),
        .BATCH_NB       (BNB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .s_rst          (s_rst),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_pid        (req_pid),
        .flush          (flush),
        .bcmd_vld       (bcmd_vld),
        .bcmd_rdy       (bcmd_rdy),
        .bcmd_pid_first (bcmd_pid_first),
        .bcmd_pbs_nb    (bcmd_pbs_nb),
        .batch_done     (batch_done),
        .pbs_free_vld   (pbs_free_vld),
        .pbs_free_nb    (pbs_free_nb),
        .free_cnt       (free_cnt),
        .inflight_cnt   (inflight_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference model: credits as integers, the open batch as a queue of
    // slot ids, and at most one closed batch waiting to be issued.
    int m_free, m_inflight, m_next_pid, m_age;
    int m_open[$];
    bit m_cmd;
    int m_cmd_first, m_cmd_nb;

    task automatic model_reset();
        m_free      = TOTAL;
        m_inflight  = 0;
        m_next_pid  = 0;
        m_age       = 0;
        m_open.delete();
        m_cmd       = 1'b0;
        m_cmd_first = 0;
        m_cmd_nb    = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model by the rules for this cycle.
    task automatic cycle(input bit rst, input bit rv, input bit fl, input bit br,
                         input bit bd, input bit fv, input int fnb);
        bit e_rdy, e_bvld, acc, hs;
        @(negedge clk);
        s_rst        = rst;
        req_vld      = rv;
        flush        = fl;
        bcmd_rdy     = br;
        batch_done   = bd;
        pbs_free_vld = fv;
        pbs_free_nb  = NB_W'(fnb);
        #1;
        e_rdy  = !rst && !m_cmd && (m_free > 0);
        e_bvld = !rst && m_cmd && (m_inflight < BNB);
        check_val("req_rdy", int'(req_rdy), int'(e_rdy));
        if (e_rdy) check_val("req_pid", int'(req_pid), m_next_pid);
        check_val("bcmd_vld", int'(bcmd_vld), int'(e_bvld));
        if (e_bvld) begin
            check_val("bcmd_pid_first", int'(bcmd_pid_first), m_cmd_first);
            check_val("bcmd_pbs_nb", int'(bcmd_pbs_nb), m_cmd_nb);
        end
        check_val("free_cnt", int'(free_cnt), m_free);
        check_val("inflight_cnt", int'(inflight_cnt), m_inflight);

        acc = rv && e_rdy;
        hs  = br && e_bvld;
        if (acc) $display("accept pid=%0d", req_pid);
        if (hs)  $display("bcmd   pid_first=%0d pbs_nb=%0d", bcmd_pid_first, bcmd_pbs_nb);

        if (rst) begin
            model_reset();
        end else begin
            if (hs) m_cmd = 1'b0;
            if (hs && !bd) m_inflight++;
            else if (!hs && bd && m_inflight > 0) m_inflight--;
            if (m_open.size() > 0 && m_age < TO - 1) m_age++;
            if (acc) begin
                if (m_open.size() == 0) m_age = 0;
                m_open.push_back(m_next_pid);
                m_next_pid = (m_next_pid + 1) % TOTAL;
            end
            m_free = m_free + (fv ? fnb : 0) - (acc ? 1 : 0);
            if (m_open.size() > 0 &&
                (m_open.size() == BATCH || fl || m_age == TO - 1 || m_free == 0)) begin
                m_cmd       = 1'b1;
                m_cmd_first = m_open[0];
                m_cmd_nb    = m_open.size();
                m_open.delete();
            end
        end
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : main
        bit r_rst, r_rv, r_fl, r_br, r_bd, r_fv;
        int room, r_nb;

        model_reset();

        // Reset state
        do_reset();
        check_val("rst_req_rdy", int'(req_rdy), 0);
        check_val("rst_bcmd_vld", int'(bcmd_vld), 0);
        check_val("rst_pid_first", int'(bcmd_pid_first), 0);
        check_val("rst_pbs_nb", int'(bcmd_pbs_nb), 0);
        check_val("rst_free_cnt", int'(free_cnt), TOTAL);
        check_val("rst_inflight", int'(inflight_cnt), 0);

        // Full batch of 9 back-to-back requests
        for (int i = 0; i < 9; i++) begin
            cycle(0, 1, 0, 0, 0, 0, 0);
            check_val("full_pid", int'(req_pid), i);
        end
        cycle(0, 1, 0, 0, 0, 0, 0);
        check_val("full_vld", int'(bcmd_vld), 1);
        check_val("full_first", int'(bcmd_pid_first), 0);
        check_val("full_nb", int'(bcmd_pbs_nb), 9);
        check_val("full_rdy_low", int'(req_rdy), 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check_val("full_rdy_back", int'(req_rdy), 1);

        // Timeout: 4 requests, then idle until the batch is forced closed
        do_reset();
        for (int k = 0; k <= 64; k++) begin
            cycle(0, k < 4, 0, 0, 0, 0, 0);
            if (k == 63) check_val("tmo_vld_early", int'(bcmd_vld), 0);
            if (k == 64) begin
                check_val("tmo_vld", int'(bcmd_vld), 1);
                check_val("tmo_nb", int'(bcmd_pbs_nb), 4);
            end
        end

        // Flush closes a partial batch; the next batch continues the pool
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        check_val("flush_vld", int'(bcmd_vld), 1);
        check_val("flush_nb", int'(bcmd_pbs_nb), 3);
        cycle(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        check_val("flush2_first", int'(bcmd_pid_first), 3);
        check_val("flush2_nb", int'(bcmd_pbs_nb), 2);

        // One batch in flight, 18 requests exhaust the pool
        do_reset();
        for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 1, 0, 0, 0);
            check_val("exh_vld_low", int'(bcmd_vld), 0);
            check_val("exh_rdy_low", int'(req_rdy), 0);
            check_val("exh_free", int'(free_cnt), 0);
        end
        cycle(0, 0, 0, 0, 1, 0, 0);
        check_val("exh_vld_done_cyc", int'(bcmd_vld), 0);
        cycle(0, 1, 0, 1, 0, 0, 0);
        check_val("exh_vld", int'(bcmd_vld), 1);
        check_val("exh_first", int'(bcmd_pid_first), 9);
        check_val("exh_nb", int'(bcmd_pbs_nb), 9);
        check_val("exh_rdy", int'(req_rdy), 0);

        // Wrap: release 9 slots, then reuse pids 0..8
        cycle(0, 0, 0, 0, 0, 1, 9);
        for (int i = 0; i < 9; i++) begin
            cycle(0, 1, 0, 0, 0, i == 0, (i == 0) ? 9 : 0);
            check_val("wrap_pid", int'(req_pid), i);
            if (i == 1) check_val("wrap_free_net", int'(free_cnt), 17);
        end

        // Reset while holding a command
        do_reset();
        for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check_val("rsti_vld_before", int'(bcmd_vld), 1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        check_val("rsti_vld", int'(bcmd_vld), 0);
        check_val("rsti_free", int'(free_cnt), TOTAL);
        check_val("rsti_inflight", int'(inflight_cnt), 0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_rv  = ($urandom_range(0, 3) != 0);
            r_fl  = ($urandom_range(0, 19) == 0);
            r_br  = ($urandom_range(0, 2) != 0);
            r_bd  = (m_inflight > 0) && ($urandom_range(0, 3) == 0);
            room  = TOTAL - m_free;
            r_fv  = (room > 0) && ($urandom_range(0, 4) == 0);
            r_nb  = r_fv ? int'($urandom_range(1, (room < BATCH) ? room : BATCH)) : 0;
            cycle(r_rst, r_rv, r_fl, r_br, r_bd, r_fv, r_nb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
